// File: rtl/rom_read_arbiter_if.sv
// AXI read-only requester bundle (AR + R channels) used on both arbiter slave ports.
// The master modport is the requester side; slave is the arbiter side.
interface rom_read_arbiter_if #(
    parameter int ID_W  = 8,
    parameter int LEN_W = 4
);
    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic             arvalid;
    logic             arready;
    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    modport master (
        output arid, araddr, arlen, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// Burst-granular arbiter sharing one boot-ROM port between two AXI read requesters.
// Define ROM_ARB_FIXED_PRIO_EN for fixed s0 priority; default is round-robin.
module rom_read_arbiter #(
    parameter int ID_W  = 8,
    parameter int LEN_W = 4,
    parameter int AW    = 12
) (
    input  logic                 clk,
    input  logic                 resetn,
    rom_read_arbiter_if.slave    s0,
    rom_read_arbiter_if.slave    s1,
    input  logic [31:0]          DO,
    output logic                 CS,
    output logic                 OE,
    output logic [AW-1:0]        A
);

    typedef enum logic [1:0] {IDLE, FETCH, CAPT, RESP} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ID_W-1:0]  r_id;
    logic [AW-1:0]    r_addr;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat;
    logic [31:0]      r_rdata;
    logic             r_gnt;
    logic             w_pick;
    logic             w_any;
    logic             w_ar_hs;
    logic             w_rready;
    logic             w_r_hs;
    logic             w_rlast;
    logic             w_resp0;
    logic             w_resp1;

`ifdef ROM_ARB_FIXED_PRIO_EN
    // s1 only wins when s0 is idle.
    assign w_pick = ~s0.arvalid;
`else
    logic r_last_grant;

    always_comb begin
        w_pick = ~s0.arvalid;
        if (s0.arvalid && s1.arvalid) begin
            w_pick = ~r_last_grant;
        end
    end
`endif

    assign w_any    = s0.arvalid | s1.arvalid;
    assign w_ar_hs  = (r_state == IDLE) && w_any;
    assign w_rready = r_gnt ? s1.rready : s0.rready;
    assign w_r_hs   = (r_state == RESP) && w_rready;
    assign w_rlast  = (r_beat == r_len);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        CS          = 1'b0;
        OE          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                CS          = 1'b1;
                w_state_nxt = CAPT;
            end
            CAPT: begin
                OE          = 1'b1;
                w_state_nxt = RESP;
            end
            RESP: begin
                if (w_rready) begin
                    w_state_nxt = w_rlast ? IDLE : FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_rdata <= '0;
            r_gnt   <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_id   <= w_pick ? s1.arid : s0.arid;
                r_addr <= w_pick ? s1.araddr[AW+1:2] : s0.araddr[AW+1:2];
                r_len  <= w_pick ? s1.arlen : s0.arlen;
                r_gnt  <= w_pick;
                r_beat <= '0;
            end
            if (r_state == CAPT) begin
                r_rdata <= DO;
            end
            // Address wraps naturally at the top of the ROM.
            if (w_r_hs && !w_rlast) begin
                r_addr <= r_addr + 1'b1;
                r_beat <= r_beat + 1'b1;
            end
        end
    end

`ifndef ROM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
        end else if (w_ar_hs) begin
            r_last_grant <= w_pick;
        end
    end
`endif

    assign A = r_addr;

    assign s0.arready = w_ar_hs && !w_pick;
    assign s1.arready = w_ar_hs && w_pick;

    // The idle port's R payload is forced to zero so it never sees another requester's data.
    assign w_resp0 = (r_state == RESP) && !r_gnt;
    assign w_resp1 = (r_state == RESP) && r_gnt;

    assign s0.rvalid = w_resp0;
    assign s0.rid    = w_resp0 ? r_id : '0;
    assign s0.rdata  = w_resp0 ? r_rdata : '0;
    assign s0.rlast  = w_resp0 && w_rlast;
    assign s0.rresp  = 2'b00;

    assign s1.rvalid = w_resp1;
    assign s1.rid    = w_resp1 ? r_id : '0;
    assign s1.rdata  = w_resp1 ? r_rdata : '0;
    assign s1.rlast  = w_resp1 && w_rlast;
    assign s1.rresp  = 2'b00;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a behavioural ROM model.
module tb_rom_read_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] DO;
    logic        CS;
    logic        OE;
    logic [11:0] A;

    rom_read_arbiter_if #(.ID_W(8), .LEN_W(4)) s0_if();
    rom_read_arbiter_if #(.ID_W(8), .LEN_W(4)) s1_if();

    rom_read_arbiter #(.ID_W(8), .LEN_W(4), .AW(12)) dut (
        .clk    (clk),
        .resetn (resetn),
        .s0     (s0_if),
        .s1     (s1_if),
        .DO     (DO),
        .CS     (CS),
        .OE     (OE),
        .A      (A)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [4096];
    always @(posedge clk) if (CS) DO <= rom[A];

    int vecs = 0;
    int errs = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ar(input bit p, input bit v, input logic [7:0] id,
                          input logic [31:0] addr, input logic [3:0] len);
        if (p) begin
            s1_if.arvalid = v; s1_if.arid = id; s1_if.araddr = addr; s1_if.arlen = len;
        end else begin
            s0_if.arvalid = v; s0_if.arid = id; s0_if.araddr = addr; s0_if.arlen = len;
        end
    endtask

    function automatic logic f_rvalid(input bit p);
        return p ? s1_if.rvalid : s0_if.rvalid;
    endfunction

    function automatic logic [31:0] f_rdata(input bit p);
        return p ? s1_if.rdata : s0_if.rdata;
    endfunction

    function automatic logic [7:0] f_rid(input bit p);
        return p ? s1_if.rid : s0_if.rid;
    endfunction

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_ar(0, 0, 8'h0, 32'h0, 4'h0);
        set_ar(1, 0, 8'h0, 32'h0, 4'h0);
        s0_if.rready = 1'b1;
        s1_if.rready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready, s0_if.rvalid, s1_if.rvalid, s0_if.rlast, s1_if.rlast} !== 6'b0) begin
            errs++; $display("FAIL reset_ctrl got %b exp 000000",
                {s0_if.arready, s1_if.arready, s0_if.rvalid, s1_if.rvalid, s0_if.rlast, s1_if.rlast});
        end
        vecs++;
        if ({s0_if.rid, s1_if.rid, s0_if.rresp, s1_if.rresp} !== 20'h0) begin
            errs++; $display("FAIL reset_rid_rresp got %h exp 0", {s0_if.rid, s1_if.rid, s0_if.rresp, s1_if.rresp});
        end
        vecs++;
        if ({s0_if.rdata, s1_if.rdata} !== 64'h0) begin
            errs++; $display("FAIL reset_rdata got %h exp 0", {s0_if.rdata, s1_if.rdata});
        end
        vecs++;
        if ({CS, OE, A} !== 14'h0) begin
            errs++; $display("FAIL reset_rom_pins got %h exp 0", {CS, OE, A});
        end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_single_beat();
        tick();
        set_ar(0, 1, 8'h5A, 32'h0000_0010, 4'd0);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== 2'b10) begin
            errs++; $display("FAIL single_arready got %b exp 10", {s0_if.arready, s1_if.arready});
        end
        tick();
        set_ar(0, 0, 8'h0, 32'h0, 4'd0);
        @(negedge clk);
        vecs++;
        if ({CS, OE, A, s0_if.rvalid} !== {1'b1, 1'b0, 12'd4, 1'b0}) begin
            errs++; $display("FAIL single_fetch got cs=%b oe=%b a=%0d rv=%b exp cs=1 oe=0 a=4 rv=0", CS, OE, A, s0_if.rvalid);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({CS, OE, s0_if.rvalid} !== 3'b010) begin
            errs++; $display("FAIL single_capt got %b exp 010", {CS, OE, s0_if.rvalid});
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({s0_if.rvalid, s0_if.rlast, s0_if.rresp, s0_if.rid, s0_if.rdata, CS} !== {1'b1, 1'b1, 2'b00, 8'h5A, 32'hDEADBEEF, 1'b0}) begin
            errs++; $display("FAIL single_resp got rv=%b rl=%b rr=%0d rid=%h rd=%h cs=%b exp 1 1 0 5a deadbeef 0",
                s0_if.rvalid, s0_if.rlast, s0_if.rresp, s0_if.rid, s0_if.rdata, CS);
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({s0_if.rvalid, CS} !== 2'b00) begin
            errs++; $display("FAIL single_done got %b exp 00", {s0_if.rvalid, CS});
        end
    endtask

    task automatic test_burst_stall();
        logic [31:0] exp_d [4] = '{32'hC0DE0FFE, 32'hC0DE0FFF, 32'hC0DE0000, 32'hC0DE0001};
        logic [11:0] exp_a [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        tick();
        set_ar(1, 1, 8'h33, 32'h0000_3FF8, 4'd3);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== 2'b01) begin
            errs++; $display("FAIL burst_arready got %b exp 01", {s0_if.arready, s1_if.arready});
        end
        tick();
        set_ar(1, 0, 8'h0, 32'h0, 4'd0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            vecs++;
            if ({CS, A} !== {1'b1, exp_a[b]}) begin
                errs++; $display("FAIL burst_fetch%0d got cs=%b a=%0d exp cs=1 a=%0d", b, CS, A, exp_a[b]);
            end
            tick();
            if (b == 1) s1_if.rready = 1'b0;
            @(negedge clk);
            vecs++;
            if ({CS, OE} !== 2'b01) begin
                errs++; $display("FAIL burst_capt%0d got %b exp 01", b, {CS, OE});
            end
            tick();
            if (b == 1) begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    vecs++;
                    if ({s1_if.rvalid, s1_if.rdata, CS} !== {1'b1, exp_d[1], 1'b0}) begin
                        errs++; $display("FAIL burst_stall%0d got rv=%b rd=%h cs=%b exp 1 %h 0",
                            k, s1_if.rvalid, s1_if.rdata, CS, exp_d[1]);
                    end
                    tick();
                end
                s1_if.rready = 1'b1;
            end
            @(negedge clk);
            vecs++;
            if ({s1_if.rvalid, s1_if.rdata, s1_if.rlast, s1_if.rid, s0_if.rvalid} !== {1'b1, exp_d[b], (b == 3), 8'h33, 1'b0}) begin
                errs++; $display("FAIL burst_beat%0d got rv=%b rd=%h rl=%b rid=%h s0rv=%b exp 1 %h %0d 33 0",
                    b, s1_if.rvalid, s1_if.rdata, s1_if.rlast, s1_if.rid, s0_if.rvalid, exp_d[b], (b == 3));
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if ({s1_if.rvalid, CS} !== 2'b00) begin
            errs++; $display("FAIL burst_end got %b exp 00", {s1_if.rvalid, CS});
        end
    endtask

    task automatic tie_round(input bit f);
        logic [1:0] exp_first;
        logic [1:0] exp_second;
        exp_first  = f ? 2'b01 : 2'b10;
        exp_second = f ? 2'b10 : 2'b01;
        tick();
        set_ar(0, 1, 8'h10, 32'h0000_0020, 4'd0);
        set_ar(1, 1, 8'h11, 32'h0000_0024, 4'd0);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== exp_first) begin
            errs++; $display("FAIL tie_first got %b exp %b", {s0_if.arready, s1_if.arready}, exp_first);
        end
        tick();
        set_ar(f, 0, 8'h0, 32'h0, 4'd0);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== 2'b00) begin
            errs++; $display("FAIL tie_busy got %b exp 00", {s0_if.arready, s1_if.arready});
        end
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if ({f_rvalid(f), f_rdata(f), f_rid(f)} !== {1'b1, (f ? 32'hC0DE0009 : 32'hC0DE0008), (f ? 8'h11 : 8'h10)}) begin
            errs++; $display("FAIL tie_first_resp got rv=%b rd=%h rid=%h", f_rvalid(f), f_rdata(f), f_rid(f));
        end
        tick();
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== exp_second) begin
            errs++; $display("FAIL tie_second got %b exp %b", {s0_if.arready, s1_if.arready}, exp_second);
        end
        tick();
        set_ar(!f, 0, 8'h0, 32'h0, 4'd0);
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if ({f_rvalid(!f), f_rdata(!f)} !== {1'b1, (f ? 32'hC0DE0008 : 32'hC0DE0009)}) begin
            errs++; $display("FAIL tie_second_resp got rv=%b rd=%h", f_rvalid(!f), f_rdata(!f));
        end
        tick();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        tie_round(1'b0);
        // A lone s0 burst makes s0 the last grantee before the second tie.
        tick();
        set_ar(0, 1, 8'h01, 32'h0000_0030, 4'd0);
        tick();
        set_ar(0, 0, 8'h0, 32'h0, 4'd0);
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if ({s0_if.rvalid, s0_if.rdata} !== {1'b1, 32'hC0DE000C}) begin
            errs++; $display("FAIL lone_s0 got rv=%b rd=%h exp 1 c0de000c", s0_if.rvalid, s0_if.rdata);
        end
        tick();
`ifdef ROM_ARB_FIXED_PRIO_EN
        tie_round(1'b0);
`else
        tie_round(1'b1);
`endif
    endtask

    task automatic test_isolation();
        tick();
        set_ar(0, 1, 8'h22, 32'h0000_0050, 4'd2);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== 2'b10) begin
            errs++; $display("FAIL iso_arready got %b exp 10", {s0_if.arready, s1_if.arready});
        end
        tick();
        set_ar(0, 0, 8'h0, 32'h0, 4'd0);
        set_ar(1, 1, 8'h44, 32'h0000_0078, 4'd0);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            vecs++;
            if ({s1_if.arready, s1_if.rvalid, s1_if.rlast, s1_if.rid, s1_if.rdata} !== 43'h0) begin
                errs++; $display("FAIL iso_s1_c%0d got %h exp 0", c,
                    {s1_if.arready, s1_if.rvalid, s1_if.rlast, s1_if.rid, s1_if.rdata});
            end
            if (c % 3 == 2) begin
                vecs++;
                if ({s0_if.rvalid, s0_if.rdata} !== {1'b1, 32'hC0DE0014 + 32'(c / 3)}) begin
                    errs++; $display("FAIL iso_s0_beat%0d got rv=%b rd=%h exp 1 %h", c / 3,
                        s0_if.rvalid, s0_if.rdata, 32'hC0DE0014 + 32'(c / 3));
                end
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== 2'b01) begin
            errs++; $display("FAIL iso_s1_grant got %b exp 01", {s0_if.arready, s1_if.arready});
        end
        tick();
        set_ar(1, 0, 8'h0, 32'h0, 4'd0);
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if ({s1_if.rvalid, s1_if.rdata, s1_if.rid} !== {1'b1, 32'hC0DE001E, 8'h44}) begin
            errs++; $display("FAIL iso_s1_resp got rv=%b rd=%h rid=%h exp 1 c0de001e 44", s1_if.rvalid, s1_if.rdata, s1_if.rid);
        end
        tick();
    endtask

    task automatic test_reset_midburst();
        tick();
        set_ar(0, 1, 8'h66, 32'h0000_00A0, 4'd7);
        tick();
        set_ar(0, 0, 8'h0, 32'h0, 4'd0);
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if ({s0_if.rvalid, s0_if.rdata, s0_if.rlast} !== {1'b1, 32'hC0DE0028, 1'b0}) begin
            errs++; $display("FAIL mid_beat0 got rv=%b rd=%h rl=%b exp 1 c0de0028 0", s0_if.rvalid, s0_if.rdata, s0_if.rlast);
        end
        tick();
        tick();
        tick();
        #1 resetn = 1'b0;
        #1;
        vecs++;
        if ({s0_if.rvalid, s0_if.rlast, s0_if.rid, s0_if.rdata, CS, OE, A} !== 56'h0) begin
            errs++; $display("FAIL mid_reset got rv=%b rl=%b rid=%h rd=%h cs=%b oe=%b a=%0d exp all 0",
                s0_if.rvalid, s0_if.rlast, s0_if.rid, s0_if.rdata, CS, OE, A);
        end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        tick();
        set_ar(1, 1, 8'h77, 32'h0000_00C8, 4'd0);
        @(negedge clk);
        vecs++;
        if ({s0_if.arready, s1_if.arready} !== 2'b01) begin
            errs++; $display("FAIL post_arready got %b exp 01", {s0_if.arready, s1_if.arready});
        end
        tick();
        set_ar(1, 0, 8'h0, 32'h0, 4'd0);
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            vecs++;
            if ({s0_if.rvalid, s1_if.rvalid} !== 2'b00) begin
                errs++; $display("FAIL post_wait_t%0d got %b exp 00", c, {s0_if.rvalid, s1_if.rvalid});
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if ({s1_if.rvalid, s1_if.rlast, s1_if.rid, s1_if.rdata, s0_if.rvalid} !== {1'b1, 1'b1, 8'h77, 32'hC0DE0032, 1'b0}) begin
            errs++; $display("FAIL post_resp got rv=%b rl=%b rid=%h rd=%h s0rv=%b exp 1 1 77 c0de0032 0",
                s1_if.rvalid, s1_if.rlast, s1_if.rid, s1_if.rdata, s0_if.rvalid);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'hC0DE0000 | 32'(i);
        rom[4] = 32'hDEADBEEF;
        DO = 32'h0;
        test_reset();
        test_single_beat();
        test_burst_stall();
        test_simultaneous();
        test_isolation();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
